// File: rtl/ex_mem_pipe_if.sv
// EX->MEM stage bus: upstream (execute) handshake and payload, downstream
// (memory) handshake and payload, flush request and the stall counter readout.
//   slave  : view taken by the pipeline stage itself
//   master : view taken by the surrounding execute/memory logic or a bench
interface ex_mem_pipe_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_wd;
    logic              in_wreg;
    logic [DATA_W-1:0] in_wdata;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_wd;
    logic              out_wreg;
    logic [DATA_W-1:0] out_wdata;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  flush, in_valid, in_wd, in_wreg, in_wdata, in_pc, out_ready,
        output in_ready, out_valid, out_wd, out_wreg, out_wdata, out_pc, stall_cnt
    );

    modport master (
        output flush, in_valid, in_wd, in_wreg, in_wdata, in_pc, out_ready,
        input  in_ready, out_valid, out_wd, out_wreg, out_wdata, out_pc, stall_cnt
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage register with valid/ready handshake.
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : asynchronous reset, active low
//   bus_io : ex_mem_pipe_if.slave - flush, in_* from execute, out_* to memory,
//            stall_cnt (cycles with out_valid=1 and out_ready=0, saturating)
// SKID=1 adds a second entry so in_ready can be a flop; SKID=0 is a single
// register whose in_ready is combinational from out_ready.
module ex_mem_pipe #(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned PC_W          = 32,
    parameter bit          SKID          = 1'b1,
    parameter bit          ZERO_SUPPRESS = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input logic          clk,
    input logic          rst,
    ex_mem_pipe_if.slave bus_io
);

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              load_out, load_skid, skid_to_out;
    logic              out_valid;
    logic              in_wreg_s;

    logic [ADDR_W-1:0] out_wd_q, skid_wd_q;
    logic              out_wreg_q, skid_wreg_q;
    logic [DATA_W-1:0] out_wdata_q, skid_wdata_q;
    logic [PC_W-1:0]   out_pc_q, skid_pc_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign out_valid = (state_q != StEmpty);

    // Writes to x0 are architecturally dead; drop the enable at capture.
    assign in_wreg_s = bus_io.in_wreg & ~(ZERO_SUPPRESS & (bus_io.in_wd == '0));

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (bus_io.flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (bus_io.in_valid) begin
                        load_out = 1'b1;
                        state_d  = StFull;
                    end
                end
                StFull: begin
                    if (bus_io.out_ready) begin
                        if (bus_io.in_valid) begin
                            load_out = 1'b1;
                        end else begin
                            state_d = StEmpty;
                        end
                    end else if (SKID && bus_io.in_valid) begin
                        // in_ready was already high this cycle, so the entry must be kept
                        load_skid = 1'b1;
                        state_d   = StSkid;
                    end
                end
                StSkid: begin
                    if (bus_io.out_ready) begin
                        skid_to_out = 1'b1;
                        state_d     = StFull;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StSkid);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus_io.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload registers are not touched by flush; only the valid state is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wd_q     <= '0;
            out_wreg_q   <= 1'b0;
            out_wdata_q  <= '0;
            out_pc_q     <= '0;
            skid_wd_q    <= '0;
            skid_wreg_q  <= 1'b0;
            skid_wdata_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            if (load_out) begin
                out_wd_q    <= bus_io.in_wd;
                out_wreg_q  <= in_wreg_s;
                out_wdata_q <= bus_io.in_wdata;
                out_pc_q    <= bus_io.in_pc;
            end else if (skid_to_out) begin
                out_wd_q    <= skid_wd_q;
                out_wreg_q  <= skid_wreg_q;
                out_wdata_q <= skid_wdata_q;
                out_pc_q    <= skid_pc_q;
            end
            if (load_skid) begin
                skid_wd_q    <= bus_io.in_wd;
                skid_wreg_q  <= in_wreg_s;
                skid_wdata_q <= bus_io.in_wdata;
                skid_pc_q    <= bus_io.in_pc;
            end
        end
    end

    assign bus_io.in_ready  = SKID ? in_ready_q : (bus_io.out_ready | ~out_valid);
    assign bus_io.out_valid = out_valid;
    assign bus_io.out_wd    = out_wd_q;
    assign bus_io.out_wreg  = out_wreg_q & out_valid;
    assign bus_io.out_wdata = out_wdata_q;
    assign bus_io.out_pc    = out_pc_q;
    assign bus_io.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: instance a (SKID=1, ZERO_SUPPRESS=1, CNT_W=16) and
// instance b (SKID=0, ZERO_SUPPRESS=0, CNT_W=4), driven from vector tables
// plus hand sequences for saturation and asynchronous reset.
module tb_ex_mem_pipe;

    typedef struct {
        logic        iv;
        logic [4:0]  wd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_pc;
        logic        e_ir;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_mem_pipe_if #(.ADDR_W(5), .DATA_W(32), .PC_W(32), .CNT_W(16)) if_a ();
    ex_mem_pipe_if #(.ADDR_W(5), .DATA_W(32), .PC_W(32), .CNT_W(4))  if_b ();

    ex_mem_pipe #(
        .ADDR_W(5), .DATA_W(32), .PC_W(32), .SKID(1'b1), .ZERO_SUPPRESS(1'b1), .CNT_W(16)
    ) u_a (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if_a)
    );

    ex_mem_pipe #(
        .ADDR_W(5), .DATA_W(32), .PC_W(32), .SKID(1'b0), .ZERO_SUPPRESS(1'b0), .CNT_W(4)
    ) u_b (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        if_a.in_valid  = v.iv;
        if_a.in_wd     = v.wd;
        if_a.in_wreg   = v.wr;
        if_a.in_wdata  = v.wdata;
        if_a.in_pc     = v.pc;
        if_a.out_ready = v.ordy;
        if_a.flush     = v.fl;
    endtask

    task automatic drive_b(input vec_t v);
        if_b.in_valid  = v.iv;
        if_b.in_wd     = v.wd;
        if_b.in_wreg   = v.wr;
        if_b.in_wdata  = v.wdata;
        if_b.in_pc     = v.pc;
        if_b.out_ready = v.ordy;
        if_b.flush     = v.fl;
    endtask

    task automatic chk_a(input string p, input vec_t v);
        chk({p, ".ov"},    {31'd0, if_a.out_valid}, {31'd0, v.e_ov});
        chk({p, ".wd"},    {27'd0, if_a.out_wd},    {27'd0, v.e_wd});
        chk({p, ".wreg"},  {31'd0, if_a.out_wreg},  {31'd0, v.e_wreg});
        chk({p, ".wdata"}, if_a.out_wdata,          v.e_wdata);
        chk({p, ".pc"},    if_a.out_pc,             v.e_pc);
        chk({p, ".ir"},    {31'd0, if_a.in_ready},  {31'd0, v.e_ir});
        chk({p, ".cnt"},   {16'd0, if_a.stall_cnt}, {16'd0, v.e_cnt});
    endtask

    task automatic chk_b(input string p, input vec_t v);
        chk({p, ".ov"},    {31'd0, if_b.out_valid}, {31'd0, v.e_ov});
        chk({p, ".wd"},    {27'd0, if_b.out_wd},    {27'd0, v.e_wd});
        chk({p, ".wreg"},  {31'd0, if_b.out_wreg},  {31'd0, v.e_wreg});
        chk({p, ".wdata"}, if_b.out_wdata,          v.e_wdata);
        chk({p, ".pc"},    if_b.out_pc,             v.e_pc);
        chk({p, ".cnt"},   {28'd0, if_b.stall_cnt}, {16'd0, v.e_cnt});
    endtask

    vec_t va[20];
    vec_t vb[11];
    vec_t idle;
    vec_t zero_exp;
    vec_t v;

    initial begin
        checks = 0;
        errors = 0;
        //       iv wd     wr wdata     pc          ordy fl  ov wd     wreg wdata     pc          ir cnt
        idle     = '{0, 5'd0,  0, 32'h0,   32'h0,   1, 0, 0, 5'd0,  0, 32'h0,   32'h0,   1, 16'd0};
        zero_exp = idle;
        // SKID=1: stream, x0 suppression, skid fill/drain, flush in skid, flush discard
        va[0]  = '{1, 5'd1,  1, 32'h10, 32'h100, 1, 0, 1, 5'd1,  1, 32'h10, 32'h100, 1, 16'd0};
        va[1]  = '{1, 5'd2,  1, 32'h11, 32'h104, 1, 0, 1, 5'd2,  1, 32'h11, 32'h104, 1, 16'd0};
        va[2]  = '{1, 5'd3,  1, 32'h12, 32'h108, 1, 0, 1, 5'd3,  1, 32'h12, 32'h108, 1, 16'd0};
        va[3]  = '{1, 5'd4,  1, 32'h13, 32'h10c, 1, 0, 1, 5'd4,  1, 32'h13, 32'h10c, 1, 16'd0};
        va[4]  = '{0, 5'd0,  0, 32'h0,  32'h0,   1, 0, 0, 5'd4,  0, 32'h13, 32'h10c, 1, 16'd0};
        va[5]  = '{1, 5'd0,  1, 32'haa, 32'h110, 1, 0, 1, 5'd0,  0, 32'haa, 32'h110, 1, 16'd0};
        va[6]  = '{1, 5'd5,  0, 32'hbb, 32'h114, 1, 0, 1, 5'd5,  0, 32'hbb, 32'h114, 1, 16'd0};
        va[7]  = '{0, 5'd0,  0, 32'h0,  32'h0,   1, 0, 0, 5'd5,  0, 32'hbb, 32'h114, 1, 16'd0};
        va[8]  = '{1, 5'd6,  1, 32'ha0, 32'h200, 1, 0, 1, 5'd6,  1, 32'ha0, 32'h200, 1, 16'd0};
        va[9]  = '{1, 5'd7,  1, 32'hb0, 32'h204, 0, 0, 1, 5'd6,  1, 32'ha0, 32'h200, 0, 16'd1};
        va[10] = '{1, 5'd8,  1, 32'hc0, 32'h208, 0, 0, 1, 5'd6,  1, 32'ha0, 32'h200, 0, 16'd2};
        va[11] = '{1, 5'd8,  1, 32'hc0, 32'h208, 1, 0, 1, 5'd7,  1, 32'hb0, 32'h204, 1, 16'd2};
        va[12] = '{1, 5'd8,  1, 32'hc0, 32'h208, 1, 0, 1, 5'd8,  1, 32'hc0, 32'h208, 1, 16'd2};
        va[13] = '{0, 5'd0,  0, 32'h0,  32'h0,   1, 0, 0, 5'd8,  0, 32'hc0, 32'h208, 1, 16'd2};
        va[14] = '{1, 5'd9,  1, 32'he0, 32'h300, 1, 0, 1, 5'd9,  1, 32'he0, 32'h300, 1, 16'd2};
        va[15] = '{1, 5'd10, 1, 32'hf0, 32'h304, 0, 0, 1, 5'd9,  1, 32'he0, 32'h300, 0, 16'd3};
        va[16] = '{1, 5'd11, 1, 32'h90, 32'h308, 0, 1, 0, 5'd9,  0, 32'he0, 32'h300, 1, 16'd4};
        va[17] = '{1, 5'd12, 1, 32'hd0, 32'h30c, 0, 0, 1, 5'd12, 1, 32'hd0, 32'h30c, 1, 16'd4};
        va[18] = '{0, 5'd0,  0, 32'h0,  32'h0,   1, 0, 0, 5'd12, 0, 32'hd0, 32'h30c, 1, 16'd4};
        va[19] = '{1, 5'd13, 1, 32'h55, 32'h400, 1, 1, 0, 5'd12, 0, 32'hd0, 32'h30c, 1, 16'd4};
        // SKID=0: e_ir is the combinational in_ready seen before the edge
        vb[0]  = '{1, 5'd0,  1, 32'h77, 32'h500, 1, 0, 1, 5'd0,  1, 32'h77, 32'h500, 1, 16'd0};
        vb[1]  = '{0, 5'd0,  0, 32'h0,  32'h0,   1, 0, 0, 5'd0,  0, 32'h77, 32'h500, 1, 16'd0};
        vb[2]  = '{1, 5'd6,  1, 32'ha0, 32'h200, 1, 0, 1, 5'd6,  1, 32'ha0, 32'h200, 1, 16'd0};
        vb[3]  = '{1, 5'd7,  1, 32'hb0, 32'h204, 0, 0, 1, 5'd6,  1, 32'ha0, 32'h200, 0, 16'd1};
        vb[4]  = '{1, 5'd7,  1, 32'hb0, 32'h204, 0, 0, 1, 5'd6,  1, 32'ha0, 32'h200, 0, 16'd2};
        vb[5]  = '{1, 5'd7,  1, 32'hb0, 32'h204, 1, 0, 1, 5'd7,  1, 32'hb0, 32'h204, 1, 16'd2};
        vb[6]  = '{1, 5'd8,  1, 32'hc0, 32'h208, 1, 0, 1, 5'd8,  1, 32'hc0, 32'h208, 1, 16'd2};
        vb[7]  = '{0, 5'd0,  0, 32'h0,  32'h0,   1, 0, 0, 5'd8,  0, 32'hc0, 32'h208, 1, 16'd2};
        vb[8]  = '{1, 5'd9,  1, 32'hd0, 32'h300, 0, 0, 1, 5'd9,  1, 32'hd0, 32'h300, 1, 16'd2};
        vb[9]  = '{1, 5'd10, 1, 32'he0, 32'h304, 0, 1, 0, 5'd9,  0, 32'hd0, 32'h300, 0, 16'd3};
        vb[10] = '{1, 5'd11, 1, 32'hf0, 32'h308, 0, 0, 1, 5'd11, 1, 32'hf0, 32'h308, 1, 16'd3};

        rst = 1'b0;
        drive_a(idle);
        drive_b(idle);
        repeat (2) @(posedge clk);
        #1;
        chk_a("rst_a", zero_exp);
        chk_b("rst_b", zero_exp);
        chk("rst_b.ir", {31'd0, if_b.in_ready}, 32'd1);
        #2 rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive_a(va[i]);
            @(posedge clk);
            #1;
            chk_a($sformatf("a[%0d]", i), va[i]);
        end
        drive_a(idle);

        for (int i = 0; i < 11; i++) begin
            drive_b(vb[i]);
            #1;
            chk($sformatf("b[%0d].ir", i), {31'd0, if_b.in_ready}, {31'd0, vb[i].e_ir});
            @(posedge clk);
            #1;
            chk_b($sformatf("b[%0d]", i), vb[i]);
        end

        // b held full with no ready: counter climbs from 3 and sticks at 15.
        // a is pushed into its skid state at the same time for the reset check.
        v = idle;
        v.ordy = 1'b0;
        drive_b(v);
        v = '{1, 5'd15, 1, 32'h33, 32'h700, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 16'd0};
        drive_a(v);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat[%0d]", k), {28'd0, if_b.stall_cnt},
                (3 + k > 15) ? 32'd15 : 32'(3 + k));
        end
        chk("skid_a.ir", {31'd0, if_a.in_ready}, 32'd0);
        chk("skid_a.ov", {31'd0, if_a.out_valid}, 32'd1);

        // Asynchronous reset pulsed between edges
        #2 rst = 1'b0;
        #1;
        chk_a("arst_a", zero_exp);
        chk_b("arst_b", zero_exp);
        chk("arst_b.ir", {31'd0, if_b.in_ready}, 32'd1);
        drive_a(idle);
        drive_b(idle);
        #1 rst = 1'b1;

        // Skid entry from before reset must not reappear
        v = '{1, 5'd14, 1, 32'h66, 32'h600, 1, 0, 1, 5'd14, 1, 32'h66, 32'h600, 1, 16'd0};
        drive_a(v);
        @(posedge clk);
        #1;
        chk_a("post_a0", v);
        drive_a(idle);
        v = '{0, 5'd0, 0, 32'h0, 32'h0, 1, 0, 0, 5'd14, 0, 32'h66, 32'h600, 1, 16'd0};
        @(posedge clk);
        #1;
        chk_a("post_a1", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
